// File: rtl/m_imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding,
// default memory depth and the instruction-memory write-port bundle.
package m_imem_loader_pkg;

  localparam int MAX_WORDS_DEF = 64;
  localparam int ADDR_W_DEF    = 6;

  typedef enum logic [2:0] {
    ST_LEN  = 3'd0,
    ST_DATA = 3'd1,
    ST_CHK  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // Write-port fields, shared with the instruction memory's write port.
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [31:0]           wdata;
  } imem_wr_t;

  // A zero length, or one that does not fit in memory, is rejected.
  function automatic logic len_ok(input logic [7:0] n, input int max_words);
    return (n != 8'd0) && (int'(n) <= max_words);
  endfunction

endpackage

// File: rtl/m_word_assembler.sv
// Packs four little-endian bytes into one 32-bit word and emits a one-cycle
// word_valid pulse in the cycle after the fourth byte is taken.
module m_word_assembler
  import m_imem_loader_pkg::*;
(
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  byte_cnt_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        last_byte;

  assign last_byte = byte_en_i && (cnt_q == 2'd3);

  always_comb begin
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      cnt_d = 2'd0;
      sr_d  = '0;
    end else if (byte_en_i) begin
      cnt_d = cnt_q + 2'd1;
      // Newest byte enters at the top, so byte 0 ends up in bits [7:0].
      sr_d  = {byte_i, sr_q[23:8]};
      if (last_byte) begin
        word_d  = {byte_i, sr_q};
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      cnt_q   <= 2'd0;
      sr_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign byte_cnt_o   = cnt_q;
  assign word_valid_o = valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/m_imem_loader.sv
// Byte-stream program loader: length header, LE instruction words, XOR
// checksum. Writes instruction memory and releases the CPU on a good load.
module m_imem_loader
  import m_imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_byte_valid,
  input  logic [7:0]        w_byte,
  output logic              w_byte_ready,
  output logic              w_mem_we,
  output logic [ADDR_W-1:0] w_mem_addr,
  output logic [31:0]       w_mem_wdata,
  output logic              w_cpu_hold,
  output logic              w_done,
  output logic              w_err,
  output state_e            w_dbg_state
);

  // Handshake: a byte moves on a rising edge where w_byte_valid and
  // w_byte_ready are both high; w_byte is ignored whenever valid is low.
  // The memory side has no backpressure: w_mem_we is a one-cycle strobe.

  state_e            state_q;
  logic              ready_q;
  logic              hold_q;
  logic              done_q;
  logic              err_q;
  logic [7:0]        len_q;
  logic [7:0]        idx_q;
  logic [7:0]        acc_q;
  logic [ADDR_W-1:0] addr_q;

  logic       accept;
  logic       asm_en;
  logic       asm_clear;
  logic [1:0] byte_cnt;

  assign accept    = w_byte_valid && ready_q;
  assign asm_en    = accept && (state_q == ST_DATA);
  assign asm_clear = (state_q == ST_LEN);

  m_word_assembler u_asm (
    .w_clk        (w_clk),
    .w_rst        (w_rst),
    .clear_i      (asm_clear),
    .byte_en_i    (asm_en),
    .byte_i       (w_byte),
    .byte_cnt_o   (byte_cnt),
    .word_valid_o (w_mem_we),
    .word_o       (w_mem_wdata)
  );

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q <= ST_LEN;
      ready_q <= 1'b1;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= 8'd0;
      idx_q   <= 8'd0;
      acc_q   <= 8'd0;
      addr_q  <= '0;
    end else if (accept) begin
      case (state_q)
        ST_LEN: begin
          if (len_ok(w_byte, MAX_WORDS)) begin
            len_q   <= w_byte;
            idx_q   <= 8'd0;
            acc_q   <= 8'd0;
            state_q <= ST_DATA;
          end else begin
            err_q   <= 1'b1;
            ready_q <= 1'b0;
            state_q <= ST_ERR;
          end
        end
        ST_DATA: begin
          acc_q <= acc_q ^ w_byte;
          // Address is latched with the last byte so it lines up with the strobe.
          if (byte_cnt == 2'd3) begin
            addr_q <= idx_q[ADDR_W-1:0];
            idx_q  <= idx_q + 8'd1;
            if (idx_q == len_q - 8'd1) begin
              state_q <= ST_CHK;
            end
          end
        end
        ST_CHK: begin
          ready_q <= 1'b0;
          if (w_byte == acc_q) begin
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            err_q   <= 1'b1;
            state_q <= ST_ERR;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_byte_ready = ready_q;
  assign w_mem_addr   = addr_q;
  assign w_cpu_hold   = hold_q;
  assign w_done       = done_q;
  assign w_err        = err_q;
  assign w_dbg_state  = state_q;

endmodule

// File: tb/tb_m_imem_loader.sv
// Directed bench for m_imem_loader: good loads, bad lengths, bad checksum,
// idle gaps and asynchronous reset, with a write scoreboard.
module tb_m_imem_loader;
  import m_imem_loader_pkg::*;

  logic        w_clk;
  logic        w_rst;
  logic        w_byte_valid;
  logic [7:0]  w_byte;
  logic        w_byte_ready;
  logic        w_mem_we;
  logic [5:0]  w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic        w_cpu_hold;
  logic        w_done;
  logic        w_err;
  state_e      w_dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];

  m_imem_loader #(.MAX_WORDS(64), .ADDR_W(6)) dut (
    .w_clk        (w_clk),
    .w_rst        (w_rst),
    .w_byte_valid (w_byte_valid),
    .w_byte       (w_byte),
    .w_byte_ready (w_byte_ready),
    .w_mem_we     (w_mem_we),
    .w_mem_addr   (w_mem_addr),
    .w_mem_wdata  (w_mem_wdata),
    .w_cpu_hold   (w_cpu_hold),
    .w_done       (w_done),
    .w_err        (w_err),
    .w_dbg_state  (w_dbg_state)
  );

  // clock / reset
  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // write monitor, sampled on the falling edge
  always @(negedge w_clk) begin
    if (w_mem_we) obs_q.push_back({2'b00, w_mem_addr, w_mem_wdata});
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    int n_obs;
    int n_exp;
    n_obs = obs_q.size();
    n_exp = exp_q.size();
    check({tag, "_count"}, 40'(n_obs), 40'(n_exp));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_write"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  // drivers
  task automatic apply_reset();
    @(negedge w_clk);
    w_rst = 1'b1;
    w_byte_valid = 1'b0;
    @(negedge w_clk);
    w_rst = 1'b0;
    @(posedge w_clk);
    #1;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] b);
    w_byte_valid = 1'b1;
    w_byte = b;
    @(posedge w_clk);
    #1;
  endtask

  task automatic idle(input int n);
    w_byte_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      w_byte = 8'($urandom);
      @(posedge w_clk);
      #1;
    end
  endtask

  task automatic expect_write(input logic [5:0] a, input logic [31:0] d);
    exp_q.push_back({2'b00, a, d});
  endtask

  logic [7:0] load1 [6];
  logic [7:0] load2 [10];

  initial begin
    load1 = '{8'h01, 8'h13, 8'h05, 8'h10, 8'h00, 8'h06};
    // words DEADBEEF, 12345678; good checksum 2A, sent as 2B
    load2 = '{8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12, 8'h2B};
    w_rst = 1'b1;
    w_byte_valid = 1'b0;
    w_byte = 8'h00;

    // reset values
    #12;
    check("rst_ready", 40'(w_byte_ready), 40'd1);
    check("rst_hold",  40'(w_cpu_hold),   40'd1);
    check("rst_we",    40'(w_mem_we),     40'd0);
    check("rst_addr",  40'(w_mem_addr),   40'd0);
    check("rst_wdata", 40'(w_mem_wdata),  40'd0);
    check("rst_done",  40'(w_done),       40'd0);
    check("rst_err",   40'(w_err),        40'd0);
    check("rst_state", 40'(w_dbg_state),  40'(ST_LEN));
    apply_reset();

    // N=1 back-to-back
    expect_write(6'd0, 32'h0010_0513);
    for (int i = 0; i < 5; i++) send(load1[i]);
    check("n1_we_pulse", {6'd0, w_mem_we, w_mem_addr, w_mem_wdata},
          {6'd0, 1'b1, 6'd0, 32'h0010_0513});
    send(load1[5]);
    w_byte_valid = 1'b0;
    check("n1_we_drop", 40'(w_mem_we),     40'd0);
    check("n1_done",    40'(w_done),       40'd1);
    check("n1_hold",    40'(w_cpu_hold),   40'd0);
    check("n1_ready",   40'(w_byte_ready), 40'd0);
    check("n1_err",     40'(w_err),        40'd0);
    send(8'hAA);
    w_byte_valid = 1'b0;
    idle(2);
    check("n1_done_sticky", 40'(w_done), 40'd1);
    check("n1_wdata_hold",  40'(w_mem_wdata), 40'h0010_0513);
    check_writes("n1");

    // zero length
    apply_reset();
    send(8'h00);
    w_byte_valid = 1'b0;
    check("len0_err",   40'(w_err),        40'd1);
    check("len0_ready", 40'(w_byte_ready), 40'd0);
    check("len0_hold",  40'(w_cpu_hold),   40'd1);
    check("len0_we",    40'(w_mem_we),     40'd0);
    idle(3);
    check_writes("len0");

    // length 65 exceeds depth
    apply_reset();
    send(8'h41);
    w_byte_valid = 1'b0;
    check("len65_err",   40'(w_err),        40'd1);
    check("len65_ready", 40'(w_byte_ready), 40'd0);
    check("len65_hold",  40'(w_cpu_hold),   40'd1);
    check("len65_we",    40'(w_mem_we),     40'd0);
    idle(3);
    check_writes("len65");

    // length 64 is the largest accepted
    apply_reset();
    send(8'h40);
    w_byte_valid = 1'b0;
    check("len64_err",   40'(w_err),        40'd0);
    check("len64_ready", 40'(w_byte_ready), 40'd1);
    check("len64_state", 40'(w_dbg_state),  40'(ST_DATA));

    // N=2, bad checksum
    apply_reset();
    expect_write(6'd0, 32'hDEAD_BEEF);
    expect_write(6'd1, 32'h1234_5678);
    for (int i = 0; i < 10; i++) send(load2[i]);
    w_byte_valid = 1'b0;
    check("n2_err",  40'(w_err),      40'd1);
    check("n2_done", 40'(w_done),     40'd0);
    check("n2_hold", 40'(w_cpu_hold), 40'd1);
    idle(3);
    check("n2_hold_stays", 40'(w_cpu_hold), 40'd1);
    check_writes("n2");

    // N=1 with random idle gaps
    apply_reset();
    expect_write(6'd0, 32'h0010_0513);
    for (int i = 0; i < 6; i++) begin
      send(load1[i]);
      idle($urandom_range(0, 3));
    end
    w_byte_valid = 1'b0;
    check("gap_done", 40'(w_done),     40'd1);
    check("gap_hold", 40'(w_cpu_hold), 40'd0);
    check_writes("gap");

    // async reset after 2 data bytes, then a fresh load
    apply_reset();
    send(8'h01);
    send(8'h13);
    send(8'h05);
    w_byte_valid = 1'b0;
    #2;
    w_rst = 1'b1;
    #1;
    check("arst_state", 40'(w_dbg_state),  40'(ST_LEN));
    check("arst_hold",  40'(w_cpu_hold),   40'd1);
    check("arst_ready", 40'(w_byte_ready), 40'd1);
    check("arst_we",    40'(w_mem_we),     40'd0);
    @(negedge w_clk);
    w_rst = 1'b0;
    @(posedge w_clk);
    #1;
    expect_write(6'd0, 32'hCAFE_F00D);
    send(8'h01);
    send(8'h0D);
    send(8'hF0);
    send(8'hFE);
    send(8'hCA);
    send(8'hC9);
    w_byte_valid = 1'b0;
    check("arst_reload_done", 40'(w_done), 40'd1);
    check_writes("arst_reload");

    // async reset from DONE releases nothing and re-holds the CPU at once
    #2;
    w_rst = 1'b1;
    #1;
    check("done_rst_hold",  40'(w_cpu_hold),  40'd1);
    check("done_rst_done",  40'(w_done),      40'd0);
    check("done_rst_wdata", 40'(w_mem_wdata), 40'd0);
    @(negedge w_clk);
    w_rst = 1'b0;
    @(posedge w_clk);
    #1;
    obs_q.delete();

    // async reset during the write strobe cancels it
    send(8'h01);
    send(8'h13);
    send(8'h05);
    send(8'h10);
    send(8'h00);
    w_byte_valid = 1'b0;
    check("cancel_we_before", 40'(w_mem_we), 40'd1);
    #2;
    w_rst = 1'b1;
    #1;
    check("cancel_we_after", 40'(w_mem_we),   40'd0);
    check("cancel_addr",     40'(w_mem_addr), 40'd0);
    @(negedge w_clk);
    w_rst = 1'b0;
    idle(2);
    check_writes("cancel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
